als_light_level_meter: RTL

Downstream consumer of the PMOD ALS sensor reader's 16-bit `value` word. The block periodically samples that word, extracts the 8-bit light reading, smooths it with a first-order exponential moving average, and converts the result into a 9-step light level with hysteresis and an 8-LED thermometer bar. Outputs drive board LEDs directly and feed any later display or logging stage.

---
 rtl/als_pkg.sv | 19 +
 rtl/als_light_level_meter_if.sv | 15 +
 rtl/als_ema_filter.sv | 31 +++
 rtl/als_light_level_meter.sv | 99 +++++++++
 4 files changed

// File: rtl/als_pkg.sv
// Shared constants, FSM state type and threshold helper for the ALS light level meter.
package als_pkg;

  localparam int ALS_DATA_MSB = 12;
  localparam int ALS_DATA_LSB = 5;
  localparam int LEVEL_STEP   = 28;
  localparam int LEVEL_MAX    = 8;

  typedef enum logic {
    FIRST = 1'b0,
    RUN   = 1'b1
  } ema_state_e;

  // Lower edge of level lvl in light units: T(lvl) = 28*lvl.
  function automatic logic [9:0] level_thr(input logic [3:0] lvl);
    return 10'(lvl) * 10'(LEVEL_STEP);
  endfunction

endpackage

// File: rtl/als_light_level_meter_if.sv
// Sensor word in, filtered reading / level / bar / strobes out.
interface als_light_level_meter_if;

  logic [15:0] value;
  logic [7:0]  light;
  logic [3:0]  level;
  logic [7:0]  bar;
  logic        valid;
  logic        level_change;

  // slave is the meter itself; master is whoever supplies value and consumes the results.
  modport slave  (input  value, output light, level, bar, valid, level_change);
  modport master (output value, input  light, level, bar, valid, level_change);

endinterface

// File: rtl/als_ema_filter.sv
// First-order EMA on the 8-bit light reading; the first sample after reset preloads the accumulator.
module als_ema_filter
  import als_pkg::*;
#(
  parameter int EMA_SHIFT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  ema_state_e state,
  input  logic [7:0] raw,
  output logic [7:0] light
);

  localparam int ACC_W = 8 + EMA_SHIFT;

  logic [ACC_W-1:0] acc;

  // acc - acc/2^k + raw never exceeds 255*2^k, so ACC_W bits are enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (sample) begin
      if (state == FIRST) acc <= {raw, {EMA_SHIFT{1'b0}}};
      else                acc <= acc - (acc >> EMA_SHIFT) + ACC_W'(raw);
    end
  end

  assign light = acc[ACC_W-1:EMA_SHIFT];

endmodule

// File: rtl/als_light_level_meter.sv
// Periodic sampler of the ALS word: EMA smoothing, 9-step level with hysteresis, thermometer bar.
module als_light_level_meter
  import als_pkg::*;
#(
  parameter int SAMPLE_LOG2 = 20,
  parameter int EMA_SHIFT   = 3,
  parameter int HYST        = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  als_light_level_meter_if.slave bus
);

  logic [SAMPLE_LOG2-1:0] cnt;
  logic                   tick;
  logic                   raw_vld;
  logic                   light_vld;
  logic [7:0]             raw_q;
  logic [7:0]             light;
  ema_state_e             state, state_nxt;
  logic [3:0]             level, level_nxt;
  logic                   valid_q;
  logic                   level_change_q;
  logic [9:0]             light_ext, up_thr, dn_base, dn_thr;
  logic [7:0]             bar;

  assign tick = &cnt;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      raw_q     <= '0;
      raw_vld   <= 1'b0;
      light_vld <= 1'b0;
    end else begin
      cnt       <= cnt + SAMPLE_LOG2'(1);
      raw_vld   <= tick;
      light_vld <= raw_vld;
      if (tick) raw_q <= bus.value[ALS_DATA_MSB:ALS_DATA_LSB];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FIRST;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (state == FIRST && raw_vld) state_nxt = RUN;
  end

  als_ema_filter #(.EMA_SHIFT(EMA_SHIFT)) u_ema (
    .clk   (clk),
    .rst_n (rst_n),
    .sample(raw_vld),
    .state (state),
    .raw   (raw_q),
    .light (light)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    light_ext = {2'b00, light};
    up_thr    = level_thr(level + 4'd1) + 10'(HYST);
    dn_base   = level_thr(level);
    dn_thr    = (dn_base > 10'(HYST)) ? dn_base - 10'(HYST) : '0;
    level_nxt = level;
    if (level < 4'(LEVEL_MAX) && light_ext >= up_thr)
      level_nxt = level + 4'd1;
    else if (level != 4'd0 && light_ext < dn_thr)
      level_nxt = level - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level          <= '0;
      valid_q        <= 1'b0;
      level_change_q <= 1'b0;
    end else begin
      valid_q        <= light_vld;
      level_change_q <= light_vld && (level_nxt != level);
      if (light_vld) level <= level_nxt;
    end
  end

  always_comb begin
    bar = '0;
    for (int i = 0; i < 8; i++) bar[i] = (level > 4'(i));
  end

  assign bus.light        = light;
  assign bus.level        = level;
  assign bus.bar          = bar;
  assign bus.valid        = valid_q;
  assign bus.level_change = level_change_q;

endmodule
